// File: rtl/sec_syndrome_gen.sv
// Hamming(12,8)+overall-parity SEC-DED syndrome generator with single/double error counters.
// Latency: 2 cycles (S1 captures the codeword, S2 holds the classified result).
// Backpressure: valid/ready skid-free pipeline; S2 holds while out_ready=0, in_ready falls once both stages are full.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready/code_in   13-bit received codeword (bit 12 = overall parity p0)
//   out_valid/out_ready         result handshake towards the corrector stage
//   synd_out, data_out          syndrome (0 unless correctable) and uncorrected data byte
//   err_single, err_double      classification of the word on the output
//   cnt_clr                     synchronous clear of both counters (wins over increment)
//   sec_count, ded_count        saturating single/double error event counters
module sec_syndrome_gen #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [12:0]      code_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       synd_out,
    output logic [7:0]       data_out,
    output logic             err_single,
    output logic             err_double,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] sec_count,
    output logic [CNT_W-1:0] ded_count
);

    // Hamming position masks over code_in[11:0] (bit k-1 = position k).
    // Syndrome bit i covers the positions whose index has bit i set.
    localparam logic [11:0] MASK_S0 = 12'h555; // positions 1,3,5,7,9,11
    localparam logic [11:0] MASK_S1 = 12'h666; // positions 2,3,6,7,10,11
    localparam logic [11:0] MASK_S2 = 12'h878; // positions 4,5,6,7,12
    localparam logic [11:0] MASK_S3 = 12'hF80; // positions 8..12

    typedef enum logic [1:0] {
        CLS_CLEAN  = 2'd0,
        CLS_SINGLE = 2'd1,
        CLS_DOUBLE = 2'd2
    } cls_t;

    // ------------------------------------------------------------------
    // Stage 1: raw codeword register
    // ------------------------------------------------------------------
    logic        s1_vld;
    logic [12:0] s1_code;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s2_load;  // S2 accepts a new value this cycle
    logic s1_adv;   // S1 content moves into S2 this cycle
    logic xfer;     // output word handed to downstream this cycle

    assign s2_load  = !out_valid || out_ready;
    assign s1_adv   = s1_vld && s2_load;
    assign in_ready = !s1_vld || s1_adv;
    assign xfer     = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Syndrome / classification of the S1 word
    // ------------------------------------------------------------------
    logic [3:0] syn;
    logic       ov;
    logic [7:0] data_raw;
    cls_t       cls;

    always_comb begin
        syn[0]   = ^(s1_code[11:0] & MASK_S0);
        syn[1]   = ^(s1_code[11:0] & MASK_S1);
        syn[2]   = ^(s1_code[11:0] & MASK_S2);
        syn[3]   = ^(s1_code[11:0] & MASK_S3);
        ov       = ^s1_code;
        // Data positions 3,5,6,7,9,10,11,12 map to data bits 0..7.
        data_raw = {s1_code[11], s1_code[10], s1_code[9], s1_code[8],
                    s1_code[6],  s1_code[5],  s1_code[4], s1_code[2]};
    end

    always_comb begin
        cls = CLS_CLEAN;
        if (ov) begin
            // Odd overall parity: a single flip, unless the syndrome points
            // past position 12, which only a multi-bit error can produce.
            if (syn >= 4'd13) begin
                cls = CLS_DOUBLE;
            end else begin
                cls = CLS_SINGLE;
            end
        end else if (syn != 4'd0) begin
            cls = CLS_DOUBLE;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_code <= '0;
        end else if (in_ready) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_code <= code_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 register: drives every out_* signal directly.
    // When S2 empties, the payload is zeroed so stale flags never linger.
    // The syndrome is only forwarded for the correctable class so the
    // corrector never flips a bit on a clean or uncorrectable word.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            synd_out   <= '0;
            data_out   <= '0;
            err_single <= 1'b0;
            err_double <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                synd_out   <= (cls == CLS_SINGLE) ? syn : 4'd0;
                data_out   <= data_raw;
                err_single <= (cls == CLS_SINGLE);
                err_double <= (cls == CLS_DOUBLE);
            end else begin
                synd_out   <= '0;
                data_out   <= '0;
                err_single <= 1'b0;
                err_double <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Error event counters: count on output transfers, saturate at all-ones,
    // clear has priority over a coincident increment.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_count <= '0;
        end else if (cnt_clr) begin
            sec_count <= '0;
        end else if (xfer && err_single && (sec_count != {CNT_W{1'b1}})) begin
            sec_count <= sec_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ded_count <= '0;
        end else if (cnt_clr) begin
            ded_count <= '0;
        end else if (xfer && err_double && (ded_count != {CNT_W{1'b1}})) begin
            ded_count <= ded_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sec_syndrome_gen.sv
// Directed bench for sec_syndrome_gen: hand-computed vectors, backpressure stream,
// counter saturation/clear priority and mid-stream asynchronous reset.
module tb_sec_syndrome_gen;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] code_in;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  synd_out;
    logic [7:0]  data_out;
    logic        err_single;
    logic        err_double;
    logic        cnt_clr;
    logic [7:0]  sec_count;
    logic [7:0]  ded_count;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    sec_syndrome_gen #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .code_in    (code_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .synd_out   (synd_out),
        .data_out   (data_out),
        .err_single (err_single),
        .err_double (err_double),
        .cnt_clr    (cnt_clr),
        .sec_count  (sec_count),
        .ded_count  (ded_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One word through an otherwise idle pipeline with out_ready held high.
    task automatic send_one(input logic [12:0] code, input logic [3:0] es,
                            input logic [7:0] ed, input logic esg, input logic edb);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        code_in   = code;
        #1 chk("in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("lat1_vld", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("vld",    32'(out_valid),  32'd1);
        chk("synd",   32'(synd_out),   32'(es));
        chk("data",   32'(data_out),   32'(ed));
        chk("single", 32'(err_single), 32'(esg));
        chk("double", 32'(err_double), 32'(edb));
        @(negedge clk);
    endtask

    // Stream vectors: clean 0xFF, pos5 flip, pos1+2 flip, pos12 flip
    logic [12:0] sw_code [4] = '{13'h0F77, 13'h0010, 13'h0003, 13'h0800};
    logic [3:0]  sw_synd [4] = '{4'd0, 4'd5, 4'd0, 4'd12};
    logic [7:0]  sw_data [4] = '{8'hFF, 8'h02, 8'h00, 8'h80};
    logic        sw_sng  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic        sw_dbl  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int wi;
        int ri;
        int hold_err;
        int saw_stall;
        logic held;
        logic [3:0] p_synd;
        logic [7:0] p_data;
        logic p_sng;
        logic p_dbl;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        code_in   = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;

        // Reset state
        #12;
        chk("rst_vld",    32'(out_valid),  32'd0);
        chk("rst_synd",   32'(synd_out),   32'd0);
        chk("rst_data",   32'(data_out),   32'd0);
        chk("rst_single", 32'(err_single), 32'd0);
        chk("rst_double", 32'(err_double), 32'd0);
        chk("rst_sec",    32'(sec_count),  32'd0);
        chk("rst_ded",    32'(ded_count),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed single words
        send_one(13'h0000, 4'd0,  8'h00, 1'b0, 1'b0);
        chk("sec_after_clean", 32'(sec_count), 32'd0);
        send_one(13'h0010, 4'd5,  8'h02, 1'b1, 1'b0);
        chk("sec_after_pos5", 32'(sec_count), 32'd1);
        send_one(13'h1000, 4'd0,  8'h00, 1'b1, 1'b0);
        chk("sec_after_p0", 32'(sec_count), 32'd2);
        send_one(13'h0003, 4'd0,  8'h00, 1'b0, 1'b1);
        chk("ded_after_pos12", 32'(ded_count), 32'd1);
        send_one(13'h0089, 4'd0,  8'h00, 1'b0, 1'b1);
        chk("ded_after_syn13", 32'(ded_count), 32'd2);
        send_one(13'h0800, 4'd12, 8'h80, 1'b1, 1'b0);
        chk("sec_after_pos12", 32'(sec_count), 32'd3);
        send_one(13'h0F77, 4'd0,  8'hFF, 1'b0, 1'b0);
        chk("sec_after_clean_ff", 32'(sec_count), 32'd3);

        // Back-to-back stream with out_ready low for cycles 2..4
        wi = 0; ri = 0; hold_err = 0; saw_stall = 0; held = 1'b0;
        p_synd = '0; p_data = '0; p_sng = 1'b0; p_dbl = 1'b0;
        for (int c = 0; c < 30 && ri < 4; c++) begin
            @(negedge clk);
            out_ready = !(c >= 2 && c <= 4);
            if (wi < 4) begin
                in_valid = 1'b1;
                code_in  = sw_code[wi];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && !in_ready) saw_stall = 1;
            if (held) begin
                if (!out_valid || synd_out != p_synd || data_out != p_data ||
                    err_single != p_sng || err_double != p_dbl) hold_err++;
            end
            if (out_valid && out_ready) begin
                chk("strm_synd",   32'(synd_out),   32'(sw_synd[ri]));
                chk("strm_data",   32'(data_out),   32'(sw_data[ri]));
                chk("strm_single", 32'(err_single), 32'(sw_sng[ri]));
                chk("strm_double", 32'(err_double), 32'(sw_dbl[ri]));
                ri++;
            end
            held   = out_valid && !out_ready;
            p_synd = synd_out; p_data = data_out; p_sng = err_single; p_dbl = err_double;
            if (in_valid && in_ready) wi++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("strm_words", 32'(ri), 32'd4);
        chk("strm_stall_seen", 32'(saw_stall), 32'd1);
        chk("strm_hold_errs", 32'(hold_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("strm_out_idle", 32'(out_valid), 32'd0);
        chk("strm_sec", 32'(sec_count), 32'd5);
        chk("strm_ded", 32'(ded_count), 32'd3);

        // Saturation: 253 more single errors would reach 258, must stick at 255
        for (int i = 0; i < 253; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            code_in  = 13'h0010;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("sec_saturated", 32'(sec_count), 32'd255);
        chk("ded_unchanged", 32'(ded_count), 32'd3);

        // Clear coincident with a single-error transfer
        @(negedge clk);
        in_valid = 1'b1;
        code_in  = 13'h0010;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1 chk("clr_xfer_vld", 32'(out_valid), 32'd1);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        #1;
        chk("clr_wins_sec", 32'(sec_count), 32'd0);
        chk("clr_ded", 32'(ded_count), 32'd0);

        // Mid-stream asynchronous reset
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            code_in  = 13'h0010;
        end
        #1;
        chk("pre_rst_vld", 32'(out_valid), 32'd1);
        chk("pre_rst_sec", 32'(sec_count), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_vld", 32'(out_valid), 32'd0);
        chk("async_rst_sec", 32'(sec_count), 32'd0);
        chk("async_rst_single", 32'(err_single), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 chk("rerst_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("flushed_vld", 32'(out_valid), 32'd0);
        chk("flushed_sec", 32'(sec_count), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
